uart_cmd_receiver: RTL and testbench

- Receive-side companion to the periodic register-dump transmitter.
- Deserializes an 8N1 UART stream on `uart_rx`, parses ASCII register-write commands of the form `rN=HHHH<CR|LF>`, and emits a single-cycle write strobe with address and data.
- Sits between the board UART RX pin and the CPU register file / debug write port, so a host terminal can poke registers.
- Self-contained: it has its own oversampled bit-timing logic and does not use the UART IP.

---
 rtl/uart_cmd_receiver.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_receiver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART receiver that parses "rN=HHHH<CR|LF>" register-write commands
// and issues a one-cycle write strobe with address and data.
module uart_cmd_receiver #(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic        cmd_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE, P_IDX, P_EQ, P_HEX, P_END, P_SKIP
  } p_state_t;

  logic       rx_s1;
  logic       rxs;
  logic       rxs_d;
  logic [1:0] settle;
  logic       fall;

  // Edges only count once rxs and rxs_d both hold real line samples,
  // so a line held low through reset release must rise before a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
      settle <= 2'd0;
    end else begin
      rx_s1 <= uart_rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
      if (settle != 2'd3)
        settle <= settle + 2'd1;
    end
  end

  assign fall = (settle == 2'd3) && rxs_d && !rxs;

  rx_state_t     rx_state;
  rx_state_t     rx_nxt;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [7:0]    rx_shift;
  logic [7:0]    shift_nxt;
  logic          stop_hit;
  logic          stop_hit_q;
  logic          stop_bit_q;
  logic          byte_valid;

  always_comb begin
    rx_nxt    = rx_state;
    cnt_nxt   = baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = rx_shift;
    stop_hit  = 1'b0;
    unique case (rx_state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall) begin
          rx_nxt  = START;
          bit_nxt = 3'd7;
        end
      end
      START: begin
        if (baud_cnt == HALF_M1) begin
          cnt_nxt = '0;
          rx_nxt  = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == DIV_M1) begin
          cnt_nxt   = '0;
          shift_nxt = {rxs, rx_shift[7:1]};
          bit_nxt   = bit_cnt - 3'd1;
          if (bit_cnt == 3'd0)
            rx_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == DIV_M1) begin
          cnt_nxt  = '0;
          stop_hit = 1'b1;
          rx_nxt   = rxs ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rxs)
          rx_nxt = IDLE;
      end
      default: rx_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'd0;
      stop_hit_q <= 1'b0;
      stop_bit_q <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_nxt;
      baud_cnt   <= cnt_nxt;
      bit_cnt    <= bit_nxt;
      rx_shift   <= shift_nxt;
      stop_hit_q <= stop_hit;
      stop_bit_q <= rxs;
      byte_valid <= stop_hit_q && stop_bit_q;
      frame_err  <= stop_hit_q && !stop_bit_q;
    end
  end

  logic [7:0] ch;
  logic       is_eol;
  logic       is_r;
  logic       is_idx;
  logic       is_eq;
  logic       is_dig;
  logic       is_up;
  logic       is_lo;
  logic       is_hex;
  logic [3:0] nib;

  assign ch     = rx_shift;
  assign is_eol = (ch == 8'h0D) || (ch == 8'h0A);
  assign is_r   = (ch == 8'h72) || (ch == 8'h52);
  assign is_idx = (ch[7:3] == 5'b00110);
  assign is_eq  = (ch == 8'h3D);
  assign is_dig = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_up  = (ch >= 8'h41) && (ch <= 8'h46);
  assign is_lo  = (ch >= 8'h61) && (ch <= 8'h66);
  assign is_hex = is_dig || is_up || is_lo;

  always_comb begin
    nib = 4'd0;
    unique case (1'b1)
      is_dig:         nib = ch[3:0];
      is_up || is_lo: nib = ch[3:0] + 4'd9;
      default:        nib = 4'd0;
    endcase
  end

  p_state_t    p_state;
  p_state_t    p_nxt;
  logic [2:0]  sh_addr;
  logic [2:0]  sa_nxt;
  logic [15:0] sh_data;
  logic [15:0] sd_nxt;
  logic [1:0]  nib_cnt;
  logic [1:0]  nc_nxt;
  logic        commit;
  logic        err;

  always_comb begin
    p_nxt  = p_state;
    sa_nxt = sh_addr;
    sd_nxt = sh_data;
    nc_nxt = nib_cnt;
    commit = 1'b0;
    err    = 1'b0;
    if (frame_err) begin
      p_nxt = P_IDLE;
    end else if (byte_valid) begin
      unique case (p_state)
        P_IDLE: begin
          if (is_r) p_nxt = P_IDX;
          else if (!is_eol) err = 1'b1;
        end
        P_IDX: begin
          if (is_idx) begin
            sa_nxt = ch[2:0];
            p_nxt  = P_EQ;
          end else begin
            err = 1'b1;
          end
        end
        P_EQ: begin
          if (is_eq) begin
            sd_nxt = 16'd0;
            nc_nxt = 2'd0;
            p_nxt  = P_HEX;
          end else begin
            err = 1'b1;
          end
        end
        P_HEX: begin
          if (is_hex) begin
            sd_nxt = {sh_data[11:0], nib};
            nc_nxt = nib_cnt + 2'd1;
            if (nib_cnt == 2'd3)
              p_nxt = P_END;
          end else begin
            err = 1'b1;
          end
        end
        P_END: begin
          if (is_eol) begin
            commit = 1'b1;
            p_nxt  = P_IDLE;
          end else begin
            err = 1'b1;
          end
        end
        P_SKIP: begin
          if (is_eol) p_nxt = P_IDLE;
        end
        default: p_nxt = P_IDLE;
      endcase
      if (err)
        p_nxt = P_SKIP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state <= P_IDLE;
      sh_addr <= 3'd0;
      sh_data <= 16'd0;
      nib_cnt <= 2'd0;
      wr_en   <= 1'b0;
      wr_addr <= 3'd0;
      wr_data <= 16'd0;
      cmd_err <= 1'b0;
    end else begin
      p_state <= p_nxt;
      sh_addr <= sa_nxt;
      sh_data <= sd_nxt;
      nib_cnt <= nc_nxt;
      wr_en   <= commit;
      cmd_err <= err;
      if (commit) begin
        wr_addr <= sh_addr;
        wr_data <= sh_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed serial stimulus for uart_cmd_receiver with a write scoreboard
// and immediate-assertion checks.
module tb_uart_cmd_receiver;

  localparam int CLK_HZ = 3_686_400;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int LAT    = HALF + 9 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        cmd_err;

  always #5 clk = ~clk;

  uart_cmd_receiver #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx(uart_rx),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_err(frame_err),
    .cmd_err(cmd_err)
  );

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    int          t;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   fails = 0;
  int   n_wr = 0;
  int   n_cmd = 0;
  int   n_frm = 0;
  int   bitp = DIV;
  logic wr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        n_wr <= n_wr + 1;
        check("wr_width", int'(wr_prev), 0);
        check("wr_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          exp_t e;
          int lat;
          e = sbq.pop_front();
          lat = cyc - e.t;
          check("wr_addr", int'(wr_addr), int'(e.a));
          check("wr_data", int'(wr_data), int'(e.d));
          check("wr_latency_ok", int'(lat >= LAT + 1 && lat <= LAT + 7), 1);
        end
      end
      if (cmd_err) n_cmd <= n_cmd + 1;
      if (frame_err) n_frm <= n_frm + 1;
    end
    wr_prev <= wr_en;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_addr"}, int'(wr_addr), 0);
    check({tag, "_data"}, int'(wr_data), 0);
    check({tag, "_pulses"}, int'({wr_en, frame_err, cmd_err}), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int rst_bit);
    uart_rx = 1'b0;
    hold(bitp);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (i == rst_bit) begin
        hold(bitp / 3);
        rst_n = 1'b0;
        check_zero("in_reset");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(bitp - bitp / 3 - 10);
      end else begin
        hold(bitp);
      end
    end
    uart_rx = stop;
    hold(bitp);
    if (!stop) begin
      uart_rx = 1'b1;
      hold(bitp);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], 1'b1, -1);
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    e.t = cyc;
    sbq.push_back(e);
  endtask

  initial begin
    hold(4);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(20);

    send_str("r3=BEEF");
    push(3'd3, 16'hBEEF);
    send_str("\015");
    hold(5);
    check("t1_wr_count", n_wr, 1);
    check("t1_cmd_err", n_cmd, 0);
    check("t1_frame_err", n_frm, 0);

    send_str("R7=00a5");
    push(3'd7, 16'h00A5);
    send_str("\015\012r0=FFFF");
    push(3'd0, 16'hFFFF);
    send_str("\012");
    hold(5);
    check("t2_wr_count", n_wr, 3);
    check("t2_cmd_err", n_cmd, 0);

    send_str("r8=1234\015");
    hold(5);
    check("t3_cmd_err", n_cmd, 1);
    check("t3_wr_count", n_wr, 3);
    check("t3_hold_data", int'(wr_data), 16'hFFFF);
    check("t3_hold_addr", int'(wr_addr), 0);
    send_str("r1=0001");
    push(3'd1, 16'h0001);
    send_str("\015");
    hold(5);
    check("t3_wr_count2", n_wr, 4);

    send_str("r2=");
    send_byte(8'h35, 1'b0, -1);
    check("t4_frame_err", n_frm, 1);
    check("t4_wr_count", n_wr, 4);
    send_str("r5=0C0C");
    push(3'd5, 16'h0C0C);
    send_str("\015");
    hold(5);
    check("t4_wr_count2", n_wr, 5);
    check("t4_cmd_err", n_cmd, 1);

    uart_rx = 1'b0;
    hold(DIV / 4);
    uart_rx = 1'b1;
    hold(3 * DIV);
    check("t5_glitch_cmd", n_cmd, 1);
    check("t5_glitch_frm", n_frm, 1);
    send_str("r4=1A2B");
    push(3'd4, 16'h1A2B);
    send_str("\015");
    hold(5);
    check("t5_wr_count", n_wr, 6);

    for (int pass = 0; pass < 2; pass++) begin
      bitp = (pass == 0) ? DIV : (DIV * 97) / 100;
      send_str("r6=1");
      send_byte(8'h32, 1'b1, 6);
      check_zero("after_reset");
      check("t6_no_wr", n_wr, 6 + pass);
      send_str("r6=3456");
      push(3'd6, 16'h3456);
      send_str("\015");
      hold(5);
      check("t6_wr_count", n_wr, 7 + pass);
      check("t6_addr_hold", int'(wr_addr), 6);
      check("t6_data_hold", int'(wr_data), 16'h3456);
    end

    hold(20);
    check("final_sb_empty", sbq.size(), 0);
    check("final_cmd_err", n_cmd, 1);
    check("final_frame_err", n_frm, 1);
    check("final_wr_count", n_wr, 8);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
